alu_execute_stage: RTL

- Execute stage that sits directly downstream of registerFile.
- Takes the two register read operands (ReadRS/ReadRT) plus a decoded op, computes a 16-bit result, and drives the write-back triple RD/WriteData/RegWrite back into registerFile's write port.
- Single-cycle ALU ops complete in 1 cycle; MUL is a 16-iteration shift-add sequence with a valid/ready input handshake.

---
 rtl/alu_execute_stage_if.sv | 28 ++
 rtl/alu_execute_stage.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/alu_execute_stage_if.sv
// Operation request and write-back bus between the issue logic, the ALU
// execute stage and the register file write port.
interface alu_execute_stage_if #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 2
);
  logic              InValid;
  logic              InReady;
  logic [2:0]        Op;
  logic [WIDTH-1:0]  OperandA;
  logic [WIDTH-1:0]  OperandB;
  logic [ADDR_W-1:0] DestIn;
  logic              WriteEnIn;
  logic [ADDR_W-1:0] RD;
  logic [WIDTH-1:0]  WriteData;
  logic              RegWrite;
  logic              Zero;

  modport master (
    output InValid, Op, OperandA, OperandB, DestIn, WriteEnIn,
    input  InReady, RD, WriteData, RegWrite, Zero
  );

  modport slave (
    input  InValid, Op, OperandA, OperandB, DestIn, WriteEnIn,
    output InReady, RD, WriteData, RegWrite, Zero
  );
endinterface

// File: rtl/alu_execute_stage.sv
// ALU execute stage: single-cycle ops write back one edge after accept,
// MUL runs a 16-iteration shift-add loop before writing back.
module alu_execute_stage #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 2
) (
  input  logic                Clock,
  input  logic                Reset,
  alu_execute_stage_if.slave  bus
);
  localparam int SH_W  = $clog2(WIDTH);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic {IDLE, MUL_RUN} state_t;

  state_t            state_reg, state_next;
  logic              single_valid_reg, single_valid_next;
  logic [2:0]        op_reg, op_next;
  logic [WIDTH-1:0]  a_reg, a_next;
  logic [WIDTH-1:0]  b_reg, b_next;
  logic [ADDR_W-1:0] dest_reg, dest_next;
  logic              we_reg, we_next;
  logic [WIDTH-1:0]  mcand_reg, mcand_next;
  logic [WIDTH-1:0]  mplier_reg, mplier_next;
  logic [WIDTH-1:0]  acc_reg, acc_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic [ADDR_W-1:0] rd_reg, rd_next;
  logic [WIDTH-1:0]  wdata_reg, wdata_next;
  logic              reg_write_reg, reg_write_next;
  logic              zero_reg, zero_next;

  logic              accept;
  logic [WIDTH-1:0]  alu_result;
  logic [WIDTH-1:0]  acc_step;

  assign accept = bus.InValid && (state_reg == IDLE);

  // Single-cycle ops are evaluated on the operands captured at accept.
  always_comb begin
    alu_result = '0;
    case (op_reg)
      OP_ADD:  alu_result = a_reg + b_reg;
      OP_SUB:  alu_result = a_reg - b_reg;
      OP_AND:  alu_result = a_reg & b_reg;
      OP_OR:   alu_result = a_reg | b_reg;
      OP_SLT:  alu_result = {{(WIDTH-1){1'b0}}, ($signed(a_reg) < $signed(b_reg))};
      OP_SLL:  alu_result = a_reg << b_reg[SH_W-1:0];
      OP_SRL:  alu_result = a_reg >> b_reg[SH_W-1:0];
      default: alu_result = '0;
    endcase
  end

  assign acc_step = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;

  always_comb begin
    state_next        = state_reg;
    single_valid_next = 1'b0;
    op_next           = op_reg;
    a_next            = a_reg;
    b_next            = b_reg;
    dest_next         = dest_reg;
    we_next           = we_reg;
    mcand_next        = mcand_reg;
    mplier_next       = mplier_reg;
    acc_next          = acc_reg;
    count_next        = count_reg;
    rd_next           = rd_reg;
    wdata_next        = wdata_reg;
    reg_write_next    = 1'b0;
    zero_next         = zero_reg;

    if (single_valid_reg) begin
      wdata_next     = alu_result;
      rd_next        = dest_reg;
      zero_next      = (alu_result == '0);
      reg_write_next = we_reg;
    end

    case (state_reg)
      IDLE: begin
        if (accept) begin
          op_next   = bus.Op;
          a_next    = bus.OperandA;
          b_next    = bus.OperandB;
          dest_next = bus.DestIn;
          we_next   = bus.WriteEnIn;
          if (bus.Op == OP_MUL) begin
            state_next  = MUL_RUN;
            mcand_next  = bus.OperandA;
            mplier_next = bus.OperandB;
            acc_next    = '0;
            count_next  = '0;
          end else begin
            single_valid_next = 1'b1;
          end
        end
      end
      MUL_RUN: begin
        acc_next    = acc_step;
        mcand_next  = mcand_reg << 1;
        mplier_next = mplier_reg >> 1;
        count_next  = count_reg + CNT_W'(1);
        // The last iteration retires the product on the same edge.
        if (count_reg == CNT_W'(WIDTH - 1)) begin
          state_next     = IDLE;
          wdata_next     = acc_step;
          rd_next        = dest_reg;
          zero_next      = (acc_step == '0);
          reg_write_next = we_reg;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_reg        <= IDLE;
      single_valid_reg <= 1'b0;
      op_reg           <= '0;
      a_reg            <= '0;
      b_reg            <= '0;
      dest_reg         <= '0;
      we_reg           <= 1'b0;
      mcand_reg        <= '0;
      mplier_reg       <= '0;
      acc_reg          <= '0;
      count_reg        <= '0;
      rd_reg           <= '0;
      wdata_reg        <= '0;
      reg_write_reg    <= 1'b0;
      zero_reg         <= 1'b0;
    end else begin
      state_reg        <= state_next;
      single_valid_reg <= single_valid_next;
      op_reg           <= op_next;
      a_reg            <= a_next;
      b_reg            <= b_next;
      dest_reg         <= dest_next;
      we_reg           <= we_next;
      mcand_reg        <= mcand_next;
      mplier_reg       <= mplier_next;
      acc_reg          <= acc_next;
      count_reg        <= count_next;
      rd_reg           <= rd_next;
      wdata_reg        <= wdata_next;
      reg_write_reg    <= reg_write_next;
      zero_reg         <= zero_next;
    end
  end

  assign bus.InReady   = (state_reg == IDLE);
  assign bus.RD        = rd_reg;
  assign bus.WriteData = wdata_reg;
  assign bus.RegWrite  = reg_write_reg;
  assign bus.Zero      = zero_reg;
endmodule
